intl_aggregator: RTL

// - Downstream of the oscillation detector and sibling interlock detectors (OV/OC/temp).
// - Latches per-source interlock flags and records the first fault plus its timestamp.
// - Drives one registered shutdown request to the MPS gate logic.
// - Enforces a minimum shutdown hold time before recovery.

---
 rtl/intl_pkg.sv | 13 +
 rtl/intl_latch_bank.sv | 43 ++++
 rtl/intl_aggregator.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/intl_pkg.sv
// Shared encodings for the interlock aggregator: FSM state values and source indices.
package intl_pkg;

    localparam logic [1:0] ST_NORMAL  = 2'd0;
    localparam logic [1:0] ST_TRIPPED = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;

    localparam int SRC_OSC  = 0;
    localparam int SRC_OV   = 1;
    localparam int SRC_OC   = 2;
    localparam int SRC_TEMP = 3;

endpackage

// File: rtl/intl_latch_bank.sv
// Per-source sticky interlock latches: masked set, source-qualified clear, set wins over clear.
module intl_latch_bank #(
    parameter int N_SRC = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_SRC-1:0] i_intl_src,
    input  logic [N_SRC-1:0] i_intl_mask,
    input  logic             i_clr,
    output logic [N_SRC-1:0] o_set,
    output logic [N_SRC-1:0] o_latch,
    output logic [N_SRC-1:0] o_latch_next,
    output logic             o_next_all_clear
);
    import intl_pkg::*;

    logic [N_SRC-1:0] set_s;
    logic [N_SRC-1:0] clr_s;
    logic [N_SRC-1:0] latch_next_s;
    logic [N_SRC-1:0] latch_r;

    // A bit only clears once its source has dropped, so a held clear auto-clears on release.
    always_comb begin
        set_s        = i_intl_src & ~i_intl_mask;
        clr_s        = {N_SRC{i_clr}} & ~i_intl_src;
        latch_next_s = set_s | (latch_r & ~clr_s);
    end

    // Latch vector register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            latch_r <= {N_SRC{1'b0}};
        end else begin
            latch_r <= latch_next_s;
        end
    end

    assign o_set            = set_s;
    assign o_latch          = latch_r;
    assign o_latch_next     = latch_next_s;
    assign o_next_all_clear = (latch_next_s == {N_SRC{1'b0}});

endmodule

// File: rtl/intl_aggregator.sv
// Interlock aggregator: latches detector flags, captures the first fault and its timestamp,
// and holds a registered shutdown request for MIN_HOLD clocks after all latches clear.
module intl_aggregator
    import intl_pkg::*;
#(
    parameter int N_SRC    = 8,
    parameter int TS_W     = 32,
    parameter int MIN_HOLD = 1000,
    parameter int CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_SRC-1:0] i_intl_src,
    input  logic [N_SRC-1:0] i_intl_mask,
    input  logic             i_clr,
    output logic [N_SRC-1:0] o_intl_latch,
    output logic             o_intl,
    output logic             o_shutdown,
    output logic [N_SRC-1:0] o_first_fault,
    output logic [TS_W-1:0]  o_first_ts,
    output logic [CNT_W-1:0] o_trip_cnt,
    output logic [1:0]       o_state
);
    localparam int HOLD_W = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MIN_HOLD - 1);

    logic [N_SRC-1:0]  set_s;
    logic [N_SRC-1:0]  latch_s;
    logic [N_SRC-1:0]  latch_next_s;
    logic              next_all_clear_s;
    logic              any_set_s;
    logic [1:0]        state_next_s;
    logic [HOLD_W-1:0] hold_next_s;
    logic              capture_s;

    logic [1:0]        state_r;
    logic [HOLD_W-1:0] hold_r;
    logic [TS_W-1:0]   ts_r;
    logic              shutdown_r;
    logic              intl_r;
    logic [N_SRC-1:0]  first_fault_r;
    logic [TS_W-1:0]   first_ts_r;
    logic [CNT_W-1:0]  trip_cnt_r;

    intl_latch_bank #(.N_SRC(N_SRC)) u_latch_bank (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_intl_src       (i_intl_src),
        .i_intl_mask      (i_intl_mask),
        .i_clr            (i_clr),
        .o_set            (set_s),
        .o_latch          (latch_s),
        .o_latch_next     (latch_next_s),
        .o_next_all_clear (next_all_clear_s)
    );

    assign any_set_s = |set_s;

    // Trip/recover sequencing; a re-trip from RECOVER stays in the same episode (no capture).
    always_comb begin
        state_next_s = state_r;
        hold_next_s  = hold_r;
        capture_s    = 1'b0;
        case (state_r)
            ST_NORMAL: begin
                if (any_set_s) begin
                    state_next_s = ST_TRIPPED;
                    capture_s    = 1'b1;
                end else begin
                    state_next_s = ST_NORMAL;
                end
            end
            ST_TRIPPED: begin
                if (next_all_clear_s) begin
                    state_next_s = ST_RECOVER;
                    hold_next_s  = HOLD_LOAD;
                end else begin
                    state_next_s = ST_TRIPPED;
                end
            end
            ST_RECOVER: begin
                if (any_set_s) begin
                    state_next_s = ST_TRIPPED;
                end else if (hold_r == {HOLD_W{1'b0}}) begin
                    state_next_s = ST_NORMAL;
                end else begin
                    hold_next_s = hold_r - {{(HOLD_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_next_s = ST_NORMAL;
                hold_next_s  = {HOLD_W{1'b0}};
            end
        endcase
    end

    // State, hold counter, timestamp and registered status outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r    <= ST_NORMAL;
            hold_r     <= {HOLD_W{1'b0}};
            ts_r       <= {TS_W{1'b0}};
            shutdown_r <= 1'b0;
            intl_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            hold_r     <= hold_next_s;
            ts_r       <= ts_r + TS_W'(1);
            shutdown_r <= (state_next_s != ST_NORMAL);
            intl_r     <= |latch_next_s;
        end
    end

    // First-fault capture and saturating trip count, updated only on NORMAL->TRIPPED.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            first_fault_r <= {N_SRC{1'b0}};
            first_ts_r    <= {TS_W{1'b0}};
            trip_cnt_r    <= {CNT_W{1'b0}};
        end else if (capture_s) begin
            first_fault_r <= set_s;
            first_ts_r    <= ts_r;
            if (trip_cnt_r != {CNT_W{1'b1}}) begin
                trip_cnt_r <= trip_cnt_r + CNT_W'(1);
            end else begin
                trip_cnt_r <= trip_cnt_r;
            end
        end else begin
            first_fault_r <= first_fault_r;
            first_ts_r    <= first_ts_r;
            trip_cnt_r    <= trip_cnt_r;
        end
    end

    assign o_intl_latch  = latch_s;
    assign o_intl        = intl_r;
    assign o_shutdown    = shutdown_r;
    assign o_first_fault = first_fault_r;
    assign o_first_ts    = first_ts_r;
    assign o_trip_cnt    = trip_cnt_r;
    assign o_state       = state_r;

endmodule
